// File: rtl/deser_frame_controller.sv
// deser_frame_controller
// Sequences an ss-framed serial deserializer. It counts the shifted bits of each frame and
// waits for the deserializer's ready. When the frame has the right length it captures the
// word. It then returns a one-cycle Ack.
// Accepted words go into a 2-entry output queue with a valid/ready handshake.
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   ss_i               serial select (same synchronous signal seen by the deserializer)
//   des_ready_i        deserializer in DONE
//   des_data_i         deserializer parallel word
//   des_ack_o          registered Ack back to the deserializer (one cycle)
//   out_data_o         head word of the queue
//   out_valid_o        queue non-empty
//   out_ready_i        downstream accept
//   len_err_o          sticky: frame bit count differed from FRAME_BITS
//   ovf_err_o          sticky: good frame dropped on a full queue
//   sync_err_o         sticky: deserializer ready never arrived
//   clr_err_i          synchronous clear of the sticky flags (a same-edge set wins)
//   frame_cnt_o        good frames enqueued, wraps at 255
module deser_frame_controller #(
    parameter int unsigned FRAME_BITS = 14,
    parameter int unsigned WIDTH      = 14,
    parameter int unsigned TIMEOUT    = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ss_i,
    input  logic             des_ready_i,
    input  logic [WIDTH-1:0] des_data_i,
    output logic             des_ack_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             len_err_o,
    output logic             ovf_err_o,
    output logic             sync_err_o,
    input  logic             clr_err_i,
    output logic [7:0]       frame_cnt_o
);

    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StRecv, StWaitRdy, StAck} state_e;

    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              des_ack_q, des_ack_d;
    logic [WIDTH-1:0]  mem_q [2];
    logic              head_q, head_d;
    logic [1:0]        count_q, count_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              len_q, len_d, ovf_q, ovf_d, sync_q, sync_d;

    logic push_req, set_len, set_sync, set_ovf, pop, push_ok, wr_idx;

    // Frame sequencing
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        push_req  = 1'b0;
        set_len   = 1'b0;
        set_sync  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!ss_i) begin
                    state_d   = StRecv;
                    bit_cnt_d = 5'd1;
                end
            end
            StRecv: begin
                if (!ss_i) begin
                    // Saturate so overlong frames can never wrap back to a legal count
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                end else begin
                    state_d   = StWaitRdy;
                    tmo_cnt_d = '0;
                end
            end
            StWaitRdy: begin
                if (des_ready_i) begin
                    state_d = StAck;
                    if (bit_cnt_q == 5'(FRAME_BITS)) push_req = 1'b1;
                    else                             set_len  = 1'b1;
                end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                    state_d  = StAck;
                    set_sync = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StAck: begin
                // ss ignored here, just as the deserializer ignores it in DONE
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
            default: state_d = StIdle;
        endcase
        // StAck lasts exactly one cycle, so the Ack is a single-cycle pulse
        des_ack_d = (state_d == StAck);
    end

    // Output queue; a pop on the same edge frees room for a push into a full queue
    always_comb begin
        pop         = (count_q != 2'd0) && out_ready_i;
        push_ok     = push_req && ((count_q != 2'd2) || pop);
        set_ovf     = push_req && !push_ok;
        wr_idx      = head_q ^ count_q[0];
        count_d     = count_q + {1'b0, push_ok} - {1'b0, pop};
        head_d      = head_q ^ pop;
        frame_cnt_d = frame_cnt_q + {7'd0, push_ok};
        len_d       = (len_q  && !clr_err_i) || set_len;
        ovf_d       = (ovf_q  && !clr_err_i) || set_ovf;
        sync_d      = (sync_q && !clr_err_i) || set_sync;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            des_ack_q   <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            head_q      <= 1'b0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            len_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            des_ack_q   <= des_ack_d;
            if (push_ok) mem_q[wr_idx] <= des_data_i;
            head_q      <= head_d;
            count_q     <= count_d;
            frame_cnt_q <= frame_cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            sync_q      <= sync_d;
        end
    end

    assign des_ack_o   = des_ack_q;
    assign out_data_o  = mem_q[head_q];
    assign out_valid_o = (count_q != 2'd0);
    assign len_err_o   = len_q;
    assign ovf_err_o   = ovf_q;
    assign sync_err_o  = sync_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_deser_frame_controller.sv
module tb_deser_frame_controller;

    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ss, des_ready, out_ready, clr_err;
    logic [13:0] des_data;
    logic        des_ack, out_valid, len_err, ovf_err, sync_err;
    logic [13:0] out_data;
    logic [7:0]  frame_cnt;

    always #5 clock = ~clock;

    deser_frame_controller #(.FRAME_BITS(14), .WIDTH(14), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .ss_i        (ss),
        .des_ready_i (des_ready),
        .des_data_i  (des_data),
        .des_ack_o   (des_ack),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .len_err_o   (len_err),
        .ovf_err_o   (ovf_err),
        .sync_err_o  (sync_err),
        .clr_err_i   (clr_err),
        .frame_cnt_o (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents, sticky flags, counter, expected Ack
    logic [13:0] mq[$];
    logic        m_len, m_ovf, m_sync, m_ack;
    logic [7:0]  m_cnt;

    int ord_mode = 0;   // 0: out_ready low, 1: high, 2: random, 3: high from decision edge
    bit clr_rand = 0;

    typedef struct {
        int          nbits;
        logic [13:0] data;
        int          delay;
        int          ord;
        bit          clr_before;
        bit          clr_dec;
        bit          e_len, e_ovf, e_sync;
        int          e_cnt;
        bit          e_valid;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("des_ack", int'(des_ack), int'(m_ack));
        chk("out_valid", int'(out_valid), int'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", int'(out_data), int'(mq[0]));
        chk("len_err", int'(len_err), int'(m_len));
        chk("ovf_err", int'(ovf_err), int'(m_ovf));
        chk("sync_err", int'(sync_err), int'(m_sync));
        chk("frame_cnt", int'(frame_cnt), int'(m_cnt));
    endtask

    function automatic void model_reset();
        mq.delete();
        m_len = 0; m_ovf = 0; m_sync = 0; m_ack = 0; m_cnt = 8'd0;
    endfunction

    // ev: 0 nothing, 1 good frame decided, 2 bad-length frame decided, 3 ready timeout
    task automatic cycle(input int ev);
        bit pop, ok, s_ovf;
        @(posedge clock);
        pop   = (mq.size() != 0) && out_ready;
        ok    = 0;
        s_ovf = 0;
        if (ev == 1) begin
            if (mq.size() < 2 || pop) ok = 1;
            else                      s_ovf = 1;
        end
        if (pop) void'(mq.pop_front());
        if (ok) begin
            mq.push_back(des_data);
            m_cnt = m_cnt + 8'd1;
        end
        m_len  = (m_len  && !clr_err) || (ev == 2);
        m_ovf  = (m_ovf  && !clr_err) || s_ovf;
        m_sync = (m_sync && !clr_err) || (ev == 3);
        m_ack  = (ev != 0);
        @(negedge clock);
        check_model();
    endtask

    function automatic logic ord_pick(input bit dec);
        case (ord_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom % 2);
            default: return dec;
        endcase
    endfunction

    function automatic logic clr_pick();
        return clr_rand ? ($urandom % 8 == 0) : 1'b0;
    endfunction

    task automatic idle(input bit clr);
        ss = 1; des_ready = 0; out_ready = ord_pick(1);
        clr_err = clr ? 1'b1 : clr_pick();
        cycle(0);
        clr_err = 0;
    endtask

    // delay: number of WAIT_RDY edges with ready low before ready rises
    task automatic run_frame(input int nbits, input logic [13:0] data, input int delay,
                             input bit clr_dec);
        for (int i = 0; i < nbits; i++) begin
            ss = 0; des_ready = 0; des_data = 14'($urandom);
            out_ready = ord_pick(0); clr_err = clr_pick();
            cycle(0);
        end
        ss = 1; des_ready = 0; out_ready = ord_pick(0); clr_err = clr_pick();
        cycle(0);
        for (int k = 0; k < TIMEOUT; k++) begin
            bit dec;
            dec = (k == delay) || (k == TIMEOUT - 1);
            ss = 1; out_ready = ord_pick(dec);
            clr_err = (dec && clr_dec) ? 1'b1 : clr_pick();
            if (k == delay) begin
                des_ready = 1; des_data = data;
                cycle((nbits == 14) ? 1 : 2);
                break;
            end
            des_ready = 0; des_data = 14'($urandom);
            if (k == TIMEOUT - 1) begin
                cycle(3);
                break;
            end
            cycle(0);
        end
        // Ack cycle: ss and ready are don't-care for the controller here
        ss = 1'($urandom % 2); des_ready = 1'($urandom % 2);
        out_ready = ord_pick(1); clr_err = clr_pick();
        cycle(0);
        ss = 1; des_ready = 0; clr_err = 0;
    endtask

    initial begin
        tbl[0]  = '{14, 14'h2A5C, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{13, 14'h1111, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[2]  = '{15, 14'h2222, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[3]  = '{40, 14'h3333, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[4]  = '{14, 14'h0001, 0, 0, 1, 0, 0, 0, 0, 2, 1};
        tbl[5]  = '{14, 14'h0002, 1, 0, 0, 0, 0, 0, 0, 3, 1};
        tbl[6]  = '{14, 14'h0003, 2, 0, 0, 0, 0, 1, 0, 3, 1};
        tbl[7]  = '{14, 14'h0004, 0, 3, 0, 0, 0, 1, 0, 4, 1};
        tbl[8]  = '{14, 14'h0555, 4, 1, 0, 0, 0, 1, 1, 4, 0};
        tbl[9]  = '{14, 14'h3FFF, 3, 1, 1, 0, 0, 0, 0, 5, 0};
        tbl[10] = '{31, 14'h0666, 0, 1, 0, 0, 1, 0, 0, 5, 0};
        tbl[11] = '{30, 14'h0777, 0, 1, 1, 0, 1, 0, 0, 5, 0};
        tbl[12] = '{13, 14'h0888, 0, 1, 1, 1, 1, 0, 0, 5, 0};

        resetn = 0; ss = 1; des_ready = 0; des_data = '0; out_ready = 0; clr_err = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("reset out_data", int'(out_data), 0);
        check_model();
        resetn = 1;
        idle(0);

        // Directed table
        for (int r = 0; r < 13; r++) begin
            ord_mode = tbl[r].ord;
            if (tbl[r].clr_before) idle(1);
            run_frame(tbl[r].nbits, tbl[r].data, tbl[r].delay, tbl[r].clr_dec);
            chk($sformatf("row%0d len_err", r), int'(len_err), int'(tbl[r].e_len));
            chk($sformatf("row%0d ovf_err", r), int'(ovf_err), int'(tbl[r].e_ovf));
            chk($sformatf("row%0d sync_err", r), int'(sync_err), int'(tbl[r].e_sync));
            chk($sformatf("row%0d frame_cnt", r), int'(frame_cnt), tbl[r].e_cnt);
            chk($sformatf("row%0d out_valid", r), int'(out_valid), int'(tbl[r].e_valid));
        end

        // Reset mid-frame with a non-empty queue
        ord_mode = 0;
        run_frame(14, 14'h1234, 0, 0);
        chk("pre-reset out_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            ss = 0; cycle(0);
        end
        resetn = 0;
        #1;
        chk("async rst des_ack", int'(des_ack), 0);
        chk("async rst out_valid", int'(out_valid), 0);
        chk("async rst out_data", int'(out_data), 0);
        chk("async rst flags", int'({len_err, ovf_err, sync_err}), 0);
        chk("async rst frame_cnt", int'(frame_cnt), 0);
        model_reset();
        ss = 1;
        @(negedge clock);
        resetn = 1;
        ord_mode = 1;
        idle(0);
        run_frame(14, 14'h0ABC, 0, 0);
        chk("post-reset frame_cnt", int'(frame_cnt), 1);

        // Counter wrap: 260 more good frames leaves 261 mod 256
        for (int i = 0; i < 260; i++) run_frame(14, 14'($urandom), 0, 0);
        chk("wrap frame_cnt", int'(frame_cnt), 5);

        // Randomized traffic against the model
        ord_mode = 2;
        clr_rand = 1;
        for (int f = 0; f < 80; f++) begin
            int nb, gap;
            nb  = ($urandom % 3 == 0) ? int'($urandom_range(1, 40)) : 14;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle(0);
            run_frame(nb, 14'($urandom), int'($urandom_range(0, 5)), 1'($urandom % 4 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
